// File: rtl/bias_accum_ctrl.sv
// bias_accum_ctrl: sequences the bias-add stage behind a 16-lane adder tree.
//
// It accumulates N_PASS partial-sum vectors for one output-channel group.
// It then adds the group's bias vector once, saturates each lane to DATA_W
// bits and hands the result downstream over a valid/ready handshake.
//
// Optional build macro BIAS_ACCUM_RELU_EN: when defined, negative lanes are
// zeroed after saturation. Latency is the same in both builds.
//
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset
//   start      begin a new group (honoured only in IDLE)
//   in_valid   partial-sum vector handshake (in_ready out)
//   in_data    N_adder_tree lanes of DATA_W-bit partial sums
//   bias_in    N_adder_tree lanes of DATA_W-bit bias, sampled in BIAS only
//   out_valid  result vector handshake (out_ready in)
//   out_data   biased, saturated result vector
//   busy       high whenever not IDLE
//   done       pulses on the cycle a result is accepted
//   pass_cnt   partial sums accepted in the current group
module bias_accum_ctrl #(
  parameter int unsigned N_adder_tree = 16,
  parameter int unsigned DATA_W       = 18,
  parameter int unsigned ACC_W        = 24,
  parameter int unsigned N_PASS       = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [N_adder_tree*DATA_W-1:0]   in_data,
  input  logic [N_adder_tree*DATA_W-1:0]   bias_in,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [N_adder_tree*DATA_W-1:0]   out_data,
  output logic                             busy,
  output logic                             done,
  output logic [$clog2(N_PASS+1)-1:0]      pass_cnt
);

  localparam int unsigned CNT_W = $clog2(N_PASS + 1);

  // Saturation bounds in the (ACC_W+1)-bit sum domain.
  localparam logic signed [ACC_W:0] SAT_MAX =
      {{(ACC_W + 2 - DATA_W){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN =
      {{(ACC_W + 2 - DATA_W){1'b1}}, {(DATA_W - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StAccum, StBias, StOut} state_e;

  state_e                           state_q, state_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic [ACC_W-1:0]                 acc_q [N_adder_tree];
  logic [N_adder_tree*DATA_W-1:0]   out_data_q;
  logic signed [ACC_W:0]            sum [N_adder_tree];
  logic [DATA_W-1:0]                lane_res [N_adder_tree];
  logic                             clr_acc, add_acc, load_out;

  // Control FSM next-state logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_acc  = 1'b0;
    add_acc  = 1'b0;
    load_out = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          clr_acc = 1'b1;
          cnt_d   = '0;
          state_d = StAccum;
        end
      end
      StAccum: begin
        if (in_valid) begin
          add_acc = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(N_PASS - 1)) state_d = StBias;
        end
      end
      StBias: begin
        load_out = 1'b1;
        state_d  = StOut;
      end
      StOut: begin
        if (out_ready) begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Per-lane bias add and clamp; bias is sign-extended to ACC_W+1 bits so the
  // sum cannot overflow before the clamp.
  always_comb begin
    for (int i = 0; i < int'(N_adder_tree); i++) begin
      sum[i] = {acc_q[i][ACC_W-1], acc_q[i]}
             + {{(ACC_W + 1 - DATA_W){bias_in[DATA_W*i + DATA_W - 1]}},
                bias_in[DATA_W*i +: DATA_W]};
      if (sum[i] > SAT_MAX) begin
        lane_res[i] = SAT_MAX[DATA_W-1:0];
      end else if (sum[i] < SAT_MIN) begin
        lane_res[i] = SAT_MIN[DATA_W-1:0];
      end else begin
        lane_res[i] = sum[i][DATA_W-1:0];
      end
`ifdef BIAS_ACCUM_RELU_EN
      if (sum[i][ACC_W]) lane_res[i] = '0;
`else
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      out_data_q <= '0;
      for (int i = 0; i < int'(N_adder_tree); i++) acc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < int'(N_adder_tree); i++) begin
        if (clr_acc) begin
          acc_q[i] <= '0;
        end else if (add_acc) begin
          acc_q[i] <= acc_q[i]
                    + {{(ACC_W - DATA_W){in_data[DATA_W*i + DATA_W - 1]}},
                       in_data[DATA_W*i +: DATA_W]};
        end
        if (load_out) out_data_q[DATA_W*i +: DATA_W] <= lane_res[i];
      end
    end
  end

  assign in_ready  = (state_q == StAccum);
  assign out_valid = (state_q == StOut);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StOut) && out_ready;
  assign out_data  = out_data_q;
  assign pass_cnt  = cnt_q;

endmodule

// File: tb/tb_bias_accum_ctrl.sv
// Self-checking bench for bias_accum_ctrl (default parameters, N_PASS=3).
// Expected result vectors come from an integer model and go through a
// scoreboard queue; they are popped when the DUT presents a result.
module tb_bias_accum_ctrl;

  localparam int NL = 16;
  localparam int DW = 18;
  localparam int W  = NL * DW;
  localparam int MAXV = (1 << (DW - 1)) - 1;
  localparam int MINV = -(1 << (DW - 1));

  logic         clk = 1'b0;
  logic         rst, start, in_valid, out_ready;
  logic [W-1:0] in_data, bias_in;
  logic         in_ready, out_valid, busy, done;
  logic [W-1:0] out_data;
  logic [1:0]   pass_cnt;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] sb [$];

  bias_accum_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .bias_in  (bias_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy),
    .done     (done),
    .pass_cnt (pass_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] splat(input int v);
    logic [W-1:0] r;
    for (int i = 0; i < NL; i++) r[i*DW +: DW] = DW'(v);
    return r;
  endfunction

  function automatic logic [W-1:0] scaled(input int k);
    logic [W-1:0] r;
    for (int i = 0; i < NL; i++) r[i*DW +: DW] = DW'(i * k);
    return r;
  endfunction

  function automatic logic [W-1:0] set_lane(input logic [W-1:0] v, input int idx, input int val);
    logic [W-1:0] r;
    r = v;
    r[idx*DW +: DW] = DW'(val);
    return r;
  endfunction

  // Reference: integer sum of three partials plus bias, clamped once.
  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] c, input logic [W-1:0] bias);
    logic [W-1:0] r;
    int s;
    for (int i = 0; i < NL; i++) begin
      s = int'($signed(a[i*DW +: DW])) + int'($signed(b[i*DW +: DW]))
        + int'($signed(c[i*DW +: DW])) + int'($signed(bias[i*DW +: DW]));
      if (s > MAXV) s = MAXV;
      else if (s < MINV) s = MINV;
`ifdef BIAS_ACCUM_RELU_EN
      if (s < 0) s = 0;
`else
`endif
      r[i*DW +: DW] = DW'(s);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one partial-sum vector and hold it until it transfers.
  task automatic feed(input logic [W-1:0] d, output bit to);
    int n;
    n  = 0;
    to = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) to = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output bit to);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    to = !out_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if ({in_ready, out_valid, busy, done} !== 4'b0) begin
      bad++;
      $display("FAIL reset_ctrl got %b want 0000", {in_ready, out_valid, busy, done});
    end
    total++;
    if (out_data !== '0) begin
      bad++;
      $display("FAIL reset_data got %h want 0", out_data);
    end
    total++;
    if (pass_cnt !== 2'd0) begin
      bad++;
      $display("FAIL reset_cnt got %0d want 0", pass_cnt);
    end
  endtask

  task automatic test_basic();
    bit to;
    logic [W-1:0] exp_v;
    bias_in   = splat(1000);
    out_ready = 1'b1;
    do_start();
    sb.push_back(model(splat(100), splat(200), splat(-50), bias_in));
    feed(splat(100), to);
    feed(splat(200), to);
    feed(splat(-50), to);
    total++;
    if (to || out_valid !== 1'b0 || pass_cnt !== 2'd3 || busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_bias_cycle got to=%0b ov=%b cnt=%0d busy=%b want 0 0 3 1",
               to, out_valid, pass_cnt, busy);
    end
    tick();
    total++;
    if (out_valid !== 1'b1 || done !== 1'b1) begin
      bad++;
      $display("FAIL basic_latency got ov=%b done=%b want 1 1", out_valid, done);
    end
    exp_v = sb.pop_front();
    total++;
    if (out_data !== exp_v || out_data[DW-1:0] !== 18'd1250) begin
      bad++;
      $display("FAIL basic_data got %h want %h", out_data, exp_v);
    end
    tick();
    total++;
    if ({out_valid, done, busy} !== 3'b0 || pass_cnt !== 2'd0) begin
      bad++;
      $display("FAIL basic_return got ov/done/busy=%b cnt=%0d want 000 0",
               {out_valid, done, busy}, pass_cnt);
    end
  endtask

  task automatic test_saturation();
    bit to, t2;
    logic [W-1:0] a, b, exp_v;
    logic [DW-1:0] exp_neg;
    a = set_lane(set_lane('0, 0, 100000), 1, -100000);
    b = a;
    bias_in   = '0;
    out_ready = 1'b1;
    do_start();
    sb.push_back(model(a, b, '0, bias_in));
    feed(a, to);
    feed(b, to);
    feed('0, to);
    wait_out(t2);
    exp_v = sb.pop_front();
    total++;
    if (to || t2 || out_data !== exp_v) begin
      bad++;
      $display("FAIL sat_vector got %h want %h (timeout %0b%0b)", out_data, exp_v, to, t2);
    end
    total++;
    if (out_data[DW-1:0] !== 18'h1FFFF) begin
      bad++;
      $display("FAIL sat_pos got %h want 1ffff", out_data[DW-1:0]);
    end
`ifdef BIAS_ACCUM_RELU_EN
    exp_neg = 18'h00000;
`else
    exp_neg = 18'h20000;
`endif
    total++;
    if (out_data[2*DW-1:DW] !== exp_neg) begin
      bad++;
      $display("FAIL sat_neg got %h want %h", out_data[2*DW-1:DW], exp_neg);
    end
    tick();
  endtask

  task automatic test_stall();
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] d [3];
    logic [W-1:0] exp_v;
    int idx;
    d[0] = splat(100);
    d[1] = splat(200);
    d[2] = splat(-50);
    bias_in   = splat(1000);
    out_ready = 1'b0;
    idx = 0;
    do_start();
    sb.push_back(model(d[0], d[1], d[2], bias_in));
    for (int j = 0; j < 6; j++) begin
      in_valid = pat[j];
      in_data  = pat[j] ? d[idx] : splat(int'($urandom_range(1, 50000)));
      tick();
      if (pat[j]) idx++;
      total++;
      if (pass_cnt !== 2'(idx)) begin
        bad++;
        $display("FAIL stall_cnt%0d got %0d want %0d", j, pass_cnt, idx);
      end
    end
    in_valid = 1'b0;
    tick();
    exp_v = sb.pop_front();
    for (int k = 0; k < 5; k++) begin
      total++;
      if (out_valid !== 1'b1 || done !== 1'b0 || out_data !== exp_v) begin
        bad++;
        $display("FAIL stall_hold%0d got ov=%b done=%b data=%h want 1 0 %h",
                 k, out_valid, done, out_data, exp_v);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (done !== 1'b1 || out_data !== exp_v) begin
      bad++;
      $display("FAIL stall_release got done=%b data=%h want 1 %h", done, out_data, exp_v);
    end
    tick();
  endtask

  task automatic test_start_ignored();
    bit to, t2;
    logic [W-1:0] exp_v;
    bias_in   = splat(-7);
    out_ready = 1'b0;
    do_start();
    sb.push_back(model(splat(11), splat(22), splat(33), bias_in));
    feed(splat(11), to);
    start = 1'b1;
    tick();
    tick();
    total++;
    if (pass_cnt !== 2'd1 || busy !== 1'b1 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL start_accum got cnt=%0d busy=%b rdy=%b want 1 1 1", pass_cnt, busy, in_ready);
    end
    feed(splat(22), to);
    feed(splat(33), to);
    wait_out(t2);
    tick();
    tick();
    total++;
    if (to || t2 || out_valid !== 1'b1 || busy !== 1'b1 || pass_cnt !== 2'd3) begin
      bad++;
      $display("FAIL start_out got ov=%b busy=%b cnt=%0d want 1 1 3", out_valid, busy, pass_cnt);
    end
    exp_v = sb.pop_front();
    out_ready = 1'b1;
    #1;
    total++;
    if (done !== 1'b1 || out_data !== exp_v) begin
      bad++;
      $display("FAIL start_data got done=%b data=%h want 1 %h", done, out_data, exp_v);
    end
    tick();
    start = 1'b0;
    total++;
    if (busy !== 1'b0 || pass_cnt !== 2'd0) begin
      bad++;
      $display("FAIL start_with_done got busy=%b cnt=%0d want 0 0", busy, pass_cnt);
    end
  endtask

  task automatic test_reset_abort();
    bit to, t2;
    logic [W-1:0] exp_v;
    bias_in   = splat(5);
    out_ready = 1'b1;
    do_start();
    feed(splat(90000), to);
    feed(splat(-3000), to);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({in_ready, out_valid, busy, done} !== 4'b0 || out_data !== '0 || pass_cnt !== 2'd0) begin
      bad++;
      $display("FAIL abort_reset got ctrl=%b cnt=%0d data=%h want 0000 0 0",
               {in_ready, out_valid, busy, done}, pass_cnt, out_data);
    end
    do_start();
    sb.push_back(model(splat(1), splat(2), splat(3), bias_in));
    feed(splat(1), to);
    feed(splat(2), to);
    feed(splat(3), to);
    wait_out(t2);
    exp_v = sb.pop_front();
    total++;
    if (to || t2 || out_data !== exp_v) begin
      bad++;
      $display("FAIL abort_residue got %h want %h", out_data, exp_v);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    bit to, t2;
    logic [W-1:0] exp_v;
    out_ready = 1'b1;
    for (int g = 0; g < 2; g++) begin
      bias_in = scaled(g == 0 ? 4 : -4);
      do_start();
      sb.push_back(model(splat(10 + g), splat(-20), splat(300), bias_in));
      feed(splat(10 + g), to);
      feed(splat(-20), to);
      feed(splat(300), to);
      wait_out(t2);
      exp_v = sb.pop_front();
      total++;
      if (to || t2 || out_data !== exp_v) begin
        bad++;
        $display("FAIL b2b_group%0d got %h want %h", g, out_data, exp_v);
      end
      tick();
      total++;
      if (pass_cnt !== 2'd0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL b2b_idle%0d got cnt=%0d busy=%b want 0 0", g, pass_cnt, busy);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    bias_in   = '0;
    #1;
    test_reset();
    test_basic();
    test_saturation();
    test_stall();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
